// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order ROB commit stage with ARF writeback, retire counter and flush/redirect sequencing
module rob_commit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    AREG_WIDTH   = 5,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
    parameter int                    CNT_WIDTH    = 32,
    localparam int                   ENTRY_WIDTH  = 3*DATA_WIDTH + AREG_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst_sH,
    input  logic                   rob_deq_valid,
    input  logic [ENTRY_WIDTH-1:0] rob_deq_data,
    output logic                   rob_deq_ready,
    output logic                   arf_wr_en,
    output logic [AREG_WIDTH-1:0]  arf_wr_addr,
    output logic [DATA_WIDTH-1:0]  arf_wr_data,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [DATA_WIDTH-1:0]  redirect_pc,
    output logic [DATA_WIDTH-1:0]  epc,
    output logic [CNT_WIDTH-1:0]   retired_count
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_next;
    logic [FC_W-1:0] flush_cnt, flush_cnt_next;

    logic                  e_done, e_exc, e_mispred, e_dst_v;
    logic [AREG_WIDTH-1:0] e_dst;
    logic [DATA_WIDTH-1:0] e_result, e_pc, e_tgt;

    assign e_done    = rob_deq_data[0];
    assign e_exc     = rob_deq_data[1];
    assign e_mispred = rob_deq_data[2];
    assign e_dst_v   = rob_deq_data[3];
    assign e_dst     = rob_deq_data[4 +: AREG_WIDTH];
    assign e_result  = rob_deq_data[4 + AREG_WIDTH +: DATA_WIDTH];
    assign e_pc      = rob_deq_data[4 + AREG_WIDTH + DATA_WIDTH +: DATA_WIDTH];
    assign e_tgt     = rob_deq_data[4 + AREG_WIDTH + 2*DATA_WIDTH +: DATA_WIDTH];

    logic pop, retire, enter_flush;

    assign rob_deq_ready = (state == RUN) && e_done;
    assign pop           = rob_deq_valid && rob_deq_ready;
    assign retire        = pop && !e_exc;
    assign enter_flush   = pop && (e_exc || e_mispred);

    always_ff @(posedge clk) begin
        if (rst_sH) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // flush_cnt counts the remaining flush cycles after the current one
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (enter_flush) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sH) begin
            arf_wr_en      <= 1'b0;
            arf_wr_addr    <= '0;
            arf_wr_data    <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            epc            <= '0;
            retired_count  <= '0;
        end else begin
            arf_wr_en      <= retire && e_dst_v && (e_dst != '0);
            flush          <= (state_next == FLUSH);
            redirect_valid <= enter_flush;
            if (pop) begin
                arf_wr_addr <= e_dst;
                arf_wr_data <= e_result;
            end
            if (enter_flush) begin
                redirect_pc <= e_exc ? TRAP_VEC : e_tgt;
            end
            if (pop && e_exc) begin
                epc <= e_pc;
            end
            if (retire) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 3*DW + AW + 4;

    logic          clk = 1'b0;
    logic          rst_sH;
    logic          rob_deq_valid;
    logic [EW-1:0] rob_deq_data;
    logic          rob_deq_ready;
    logic          arf_wr_en;
    logic [AW-1:0] arf_wr_addr;
    logic [DW-1:0] arf_wr_data;
    logic          flush;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic [DW-1:0] epc;
    logic [31:0]   retired_count;

    logic          s_ready, s_wr_en, s_flush, s_rv;
    logic [AW-1:0] s_wr_addr;
    logic [DW-1:0] s_wr_data, s_rpc, s_epc;
    logic [1:0]    s_count;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk(clk), .rst_sH(rst_sH), .rob_deq_valid(rob_deq_valid), .rob_deq_data(rob_deq_data),
        .rob_deq_ready(rob_deq_ready), .arf_wr_en(arf_wr_en), .arf_wr_addr(arf_wr_addr),
        .arf_wr_data(arf_wr_data), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .epc(epc), .retired_count(retired_count)
    );

    // narrow counter instance so wraparound is reachable in a short run
    rob_commit #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_sH(rst_sH), .rob_deq_valid(rob_deq_valid), .rob_deq_data(rob_deq_data),
        .rob_deq_ready(s_ready), .arf_wr_en(s_wr_en), .arf_wr_addr(s_wr_addr),
        .arf_wr_data(s_wr_data), .flush(s_flush), .redirect_valid(s_rv),
        .redirect_pc(s_rpc), .epc(s_epc), .retired_count(s_count)
    );

    function automatic logic [EW-1:0] mk(input logic done, input logic exc, input logic mis,
                                         input logic dstv, input logic [AW-1:0] dst,
                                         input logic [DW-1:0] res, input logic [DW-1:0] pc,
                                         input logic [DW-1:0] tgt);
        return {tgt, pc, res, dst, dstv, mis, exc, done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_sH        = 1'b1;
        rob_deq_valid = 1'b0;
        rob_deq_data  = '0;
        tick();
        tick();
        rst_sH = 1'b0;
        settle();
        chk("rst_ready", rob_deq_ready, 0);
        chk("rst_wr_en", arf_wr_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_epc", epc, 0);

        // three back-to-back normal retires
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 0, 0, 1, 5'd1, 32'hA, 32'h10, 0);
        settle();
        chk("t1_ready0", rob_deq_ready, 1);
        tick();
        chk("t1_en1", arf_wr_en, 1);
        chk("t1_addr1", arf_wr_addr, 1);
        chk("t1_data1", arf_wr_data, 32'hA);
        rob_deq_data = mk(1, 0, 0, 1, 5'd2, 32'hB, 32'h14, 0);
        settle();
        chk("t1_ready1", rob_deq_ready, 1);
        tick();
        chk("t1_addr2", arf_wr_addr, 2);
        chk("t1_data2", arf_wr_data, 32'hB);
        rob_deq_data = mk(1, 0, 0, 1, 5'd3, 32'hC, 32'h18, 0);
        tick();
        chk("t1_en3", arf_wr_en, 1);
        chk("t1_addr3", arf_wr_addr, 3);
        chk("t1_data3", arf_wr_data, 32'hC);
        rob_deq_valid = 1'b0;
        tick();
        chk("t1_en_idle", arf_wr_en, 0);
        chk("t1_count", retired_count, 3);

        // head not done for four cycles
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(0, 0, 0, 1, 5'd4, 32'hD, 32'h1C, 0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_ready_wait", rob_deq_ready, 0);
            tick();
            chk("t2_en_wait", arf_wr_en, 0);
        end
        rob_deq_data = mk(1, 0, 0, 1, 5'd4, 32'hD, 32'h1C, 0);
        settle();
        chk("t2_ready_done", rob_deq_ready, 1);
        tick();
        chk("t2_en", arf_wr_en, 1);
        chk("t2_addr", arf_wr_addr, 4);
        chk("t2_data", arf_wr_data, 32'hD);
        rob_deq_valid = 1'b0;
        tick();
        chk("t2_en_after", arf_wr_en, 0);
        chk("t2_count", retired_count, 4);

        // exception at head
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 1, 0, 1, 5'd6, 32'h66, 32'h40, 32'h999);
        tick();
        rob_deq_valid = 1'b0;
        settle();
        chk("t3_en", arf_wr_en, 0);
        chk("t3_epc", epc, 32'h40);
        chk("t3_flush1", flush, 1);
        chk("t3_rv1", redirect_valid, 1);
        chk("t3_rpc", redirect_pc, 32'h100);
        chk("t3_ready_f1", rob_deq_ready, 0);
        chk("t3_count", retired_count, 4);
        tick();
        chk("t3_flush2", flush, 1);
        chk("t3_rv2", redirect_valid, 0);
        chk("t3_ready_f2", rob_deq_ready, 0);
        tick();
        chk("t3_flush3", flush, 0);
        chk("t3_ready_run", rob_deq_ready, 1);
        chk("t3_count_end", retired_count, 4);

        // mispredicted branch retires and redirects to its target
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 0, 1, 1, 5'd5, 32'h44, 32'h80, 32'h200);
        tick();
        rob_deq_valid = 1'b0;
        chk("t4_en", arf_wr_en, 1);
        chk("t4_addr", arf_wr_addr, 5);
        chk("t4_data", arf_wr_data, 32'h44);
        chk("t4_count", retired_count, 5);
        chk("t4_flush", flush, 1);
        chk("t4_rv", redirect_valid, 1);
        chk("t4_rpc", redirect_pc, 32'h200);
        chk("t4_epc", epc, 32'h40);
        tick();
        tick();
        chk("t4_flush_end", flush, 0);

        // exc and mispred together with dst=0
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 1, 1, 1, 5'd0, 32'h77, 32'h60, 32'h300);
        tick();
        rob_deq_valid = 1'b0;
        chk("t5_en", arf_wr_en, 0);
        chk("t5_rpc", redirect_pc, 32'h100);
        chk("t5_epc", epc, 32'h60);
        chk("t5_count", retired_count, 5);
        tick();
        tick();
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 0, 0, 1, 5'd0, 32'h88, 32'h64, 0);
        tick();
        chk("t5_r0_en", arf_wr_en, 0);
        chk("t5_r0_count", retired_count, 6);
        rob_deq_data = mk(1, 0, 0, 0, 5'd7, 32'h99, 32'h68, 0);
        tick();
        rob_deq_valid = 1'b0;
        chk("t5_nodst_en", arf_wr_en, 0);
        chk("t5_nodst_count", retired_count, 7);

        // reset in the first flush cycle
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 1, 0, 0, 5'd0, 0, 32'h70, 0);
        tick();
        rob_deq_valid = 1'b0;
        chk("t6_flush_pre", flush, 1);
        rst_sH = 1'b1;
        tick();
        rst_sH = 1'b0;
        settle();
        chk("t6_flush", flush, 0);
        chk("t6_rv", redirect_valid, 0);
        chk("t6_count", retired_count, 0);
        chk("t6_epc", epc, 0);
        chk("t6_ready_run", rob_deq_ready, 1);

        // four retires: wide counter reads 4, 2-bit counter wraps to 0
        rob_deq_valid = 1'b1;
        rob_deq_data  = mk(1, 0, 0, 1, 5'd9, 32'h5, 32'h90, 0);
        tick();
        tick();
        tick();
        chk("t6_small3", s_count, 3);
        tick();
        rob_deq_valid = 1'b0;
        chk("t6_small_wrap", s_count, 0);
        chk("t6_wide4", retired_count, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
